// File: rtl/keyed_dup_pkg.sv
// Shared state-encoding scheme and decode helpers for the keyed duplicated-state controllers.
// Codes: IDLE=0, Gi=1+i, Di=1+NKEY+i (D0 never used), FIN=1+2*NKEY, DFIN=2+2*NKEY.
package keyed_dup_pkg;

    localparam int unsigned SW = 5;

    typedef logic [SW-1:0] state_t;

    typedef enum logic [2:0] {
        K_IDLE,
        K_GEN,
        K_DEC,
        K_FIN,
        K_DFIN,
        K_ILL
    } kind_e;

    function automatic state_t st_idle();
        return '0;
    endfunction

    function automatic state_t st_gen(input int unsigned i);
        return SW'(1 + i);
    endfunction

    function automatic state_t st_dec(input int unsigned nkey, input int unsigned i);
        return SW'(1 + nkey + i);
    endfunction

    function automatic state_t st_fin(input int unsigned nkey);
        return SW'(1 + 2 * nkey);
    endfunction

    function automatic state_t st_dfin(input int unsigned nkey);
        return SW'(2 + 2 * nkey);
    endfunction

    function automatic kind_e state_kind(input state_t s, input int unsigned nkey);
        int unsigned v;
        v = 32'(s);
        if (v == 0)                               return K_IDLE;
        else if (v <= nkey)                       return K_GEN;
        else if (v >= nkey + 2 && v <= 2 * nkey)  return K_DEC;
        else if (v == 2 * nkey + 1)               return K_FIN;
        else if (v == 2 * nkey + 2)               return K_DFIN;
        else                                      return K_ILL;
    endfunction

    function automatic logic [2:0] state_idx(input state_t s, input int unsigned nkey);
        int unsigned v;
        v = 32'(s);
        case (state_kind(s, nkey))
            K_GEN:   return 3'(v - 1);
            K_DEC:   return 3'(v - 1 - nkey);
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] stage_of(input state_t s, input int unsigned nkey);
        case (state_kind(s, nkey))
            K_GEN, K_DEC:  return 4'(state_idx(s, nkey)) + 4'd1;
            K_FIN, K_DFIN: return 4'(nkey + 1);
            default:       return '0;
        endcase
    endfunction

endpackage

// File: rtl/keyed_dup_seq_sat_cnt.sv
// CW-bit saturating up-counter with synchronous clear; exposes the value it takes at the next edge.
module sat_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt_nxt
);

    logic [CW-1:0] r_cnt;

    always_comb begin
        o_cnt_nxt = r_cnt;
        if (i_clr)
            o_cnt_nxt = '0;
        else if (i_en && (r_cnt != '1))
            o_cnt_nxt = r_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= o_cnt_nxt;
    end

endmodule

// File: rtl/keyed_dup_seq.sv
// N-key sequencing controller with decoy twin chain; a wrong key bit silently masks the run length.
module keyed_dup_seq
    import keyed_dup_pkg::*;
#(
    parameter int unsigned          NKEY        = 4,
    parameter logic [NKEY-1:0]      CORRECT_KEY = 4'b1010,
    parameter int unsigned          CW          = 8,
    parameter logic [CW-1:0]        DECOY_MASK  = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        adv,
    input  logic                        abort,
    input  logic [NKEY-1:0]             keyinput,
    output logic [$clog2(NKEY+2)-1:0]   stage,
    output logic                        busy,
    output logic                        done,
    output logic [CW-1:0]               result
);

    localparam int unsigned SGW = $clog2(NKEY + 2);

    state_t          r_state;
    state_t          w_next;
    kind_e           w_cur_kind;
    kind_e           w_nxt_kind;
    logic [2:0]      w_cur_idx;
    logic            w_key_ok;
    logic            w_last;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic [CW-1:0]   w_cnt_nxt;
    logic [SGW-1:0]  r_stage;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_result;

    sat_cnt #(.CW(CW)) u_cnt (
        .clk       (clk),
        .i_rst_n   (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_cnt_nxt (w_cnt_nxt)
    );

    always_comb begin
        w_cur_kind = state_kind(r_state, NKEY);
        w_cur_idx  = state_idx(r_state, NKEY);
        w_key_ok   = 1'b0;
        for (int unsigned i = 0; i < NKEY; i++)
            if (32'(w_cur_idx) == i)
                w_key_ok = (keyinput[i] == CORRECT_KEY[i]);
        w_last     = (32'(w_cur_idx) == NKEY - 1);
        w_next     = st_idle();
        w_cnt_clr  = 1'b0;
        w_cnt_en   = 1'b0;
        case (w_cur_kind)
            K_IDLE: begin
                if (start) begin
                    w_next    = st_gen(0);
                    w_cnt_clr = 1'b1;
                end
            end
            K_GEN, K_DEC: begin
                w_cnt_en = 1'b1;
                if (abort)
                    w_next = st_idle();
                else if (adv) begin
                    // Decoy states never re-check the key, so once diverted the run stays masked.
                    if (w_cur_kind == K_GEN && w_key_ok)
                        w_next = w_last ? st_fin(NKEY) : st_gen(32'(w_cur_idx) + 1);
                    else
                        w_next = w_last ? st_dfin(NKEY) : st_dec(NKEY, 32'(w_cur_idx) + 1);
                end else
                    w_next = r_state;
            end
            default: w_next = st_idle();
        endcase
        w_nxt_kind = state_kind(w_next, NKEY);
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= st_idle();
            r_stage  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_stage <= SGW'(stage_of(w_next, NKEY));
            r_busy  <= (w_nxt_kind == K_GEN) || (w_nxt_kind == K_DEC);
            r_done  <= (w_nxt_kind == K_FIN) || (w_nxt_kind == K_DFIN);
            if (w_nxt_kind == K_FIN)
                r_result <= w_cnt_nxt;
            else if (w_nxt_kind == K_DFIN)
                r_result <= w_cnt_nxt ^ DECOY_MASK;
        end
    end

    assign stage  = r_stage;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_keyed_dup_seq.sv
// Randomized and directed bench for keyed_dup_seq against a run-level behavioural model (CW=8 and CW=4 instances).
module tb_keyed_dup_seq;

    localparam int unsigned NKEY  = 4;
    localparam logic [3:0]  CK    = 4'b1010;
    localparam logic [7:0]  MASK8 = 8'hA5;
    localparam logic [3:0]  MASK4 = 4'h5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, adv, abort;
    logic [3:0] keyinput;
    logic [2:0] stage8, stage4;
    logic       busy8, busy4, done8, done4;
    logic [7:0] result8;
    logic [3:0] result4;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0 = idle, 1 = at checkpoint m_pos, 2 = finishing cycle.
    int   m_phase, m_pos, m_cnt;
    bit   m_bad;
    logic [7:0] m_res8;
    logic [3:0] m_res4;

    always #5 clk = ~clk;

    keyed_dup_seq #(.NKEY(4), .CORRECT_KEY(4'b1010), .CW(8), .DECOY_MASK(8'hA5)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .adv(adv), .abort(abort), .keyinput(keyinput),
        .stage(stage8), .busy(busy8), .done(done8), .result(result8)
    );

    keyed_dup_seq #(.NKEY(4), .CORRECT_KEY(4'b1010), .CW(4), .DECOY_MASK(4'h5)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .adv(adv), .abort(abort), .keyinput(keyinput),
        .stage(stage4), .busy(busy4), .done(done4), .result(result4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_cnt = 0; m_bad = 0; m_res8 = '0; m_res4 = '0;
    endtask

    task automatic model_step();
        case (m_phase)
            0: if (start) begin m_phase = 1; m_pos = 0; m_bad = 0; m_cnt = 0; end
            1: begin
                if (abort) m_phase = 0;
                else begin
                    m_cnt++;
                    if (adv) begin
                        if (keyinput[m_pos] != CK[m_pos]) m_bad = 1;
                        if (m_pos == NKEY - 1) begin
                            m_phase = 2;
                            m_res8 = 8'((m_cnt > 255) ? 255 : m_cnt) ^ (m_bad ? MASK8 : 8'h00);
                            m_res4 = 4'((m_cnt > 15) ? 15 : m_cnt) ^ (m_bad ? MASK4 : 4'h0);
                        end else m_pos++;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_model();
        int es;
        es = (m_phase == 0) ? 0 : (m_phase == 1) ? m_pos + 1 : NKEY + 1;
        chk("stage8",  32'(stage8),  32'(es));
        chk("stage4",  32'(stage4),  32'(es));
        chk("busy8",   32'(busy8),   32'(m_phase == 1));
        chk("busy4",   32'(busy4),   32'(m_phase == 1));
        chk("done8",   32'(done8),   32'(m_phase == 2));
        chk("done4",   32'(done4),   32'(m_phase == 2));
        chk("result8", 32'(result8), 32'(m_res8));
        chk("result4", 32'(result4), 32'(m_res4));
    endtask

    task automatic cycle(input bit s, input bit a, input bit ab, input logic [3:0] k);
        start = s; adv = a; abort = ab; keyinput = k;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    // start, optional stall in G0, then four advances with the given per-checkpoint keys.
    task automatic run_keys(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                            input logic [3:0] k3, input int stall);
        logic [3:0] ks [4];
        ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
        cycle(1, 0, 0, CK);
        chk("lit_g0_stage", 32'(stage8), 32'd1);
        chk("lit_g0_busy",  32'(busy8),  32'd1);
        for (int i = 0; i < stall; i++) cycle(0, 0, 0, 4'($urandom));
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, ks[i]);
            chk("lit_adv_stage", 32'(stage8), 32'(i + 2));
        end
        chk("lit_fin_done", 32'(done8), 32'd1);
        chk("lit_fin_busy", 32'(busy8), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 0; adv = 0; abort = 0; keyinput = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("lit_rst_stage",  32'(stage8),  32'd0);
        chk("lit_rst_busy",   32'(busy8),   32'd0);
        chk("lit_rst_done",   32'(done8),   32'd0);
        chk("lit_rst_result", 32'(result8), 32'd0);
        rst = 1'b1;
        cycle(0, 0, 0, CK);

        run_keys(CK, CK, CK, CK, 0);
        chk("lit_ok_result8", 32'(result8), 32'h04);
        chk("lit_ok_result4", 32'(result4), 32'h4);
        cycle(0, 0, 0, CK);
        chk("lit_ok_idle", 32'(stage8), 32'd0);

        run_keys(4'b1011, 4'b1011, 4'b1011, 4'b1011, 0);
        chk("lit_bad0_result8", 32'(result8), 32'hA1);
        chk("lit_bad0_result4", 32'(result4), 32'h1);
        cycle(0, 0, 0, CK);

        run_keys(4'b1000, 4'b1000, CK, CK, 0);
        chk("lit_persist_result8", 32'(result8), 32'hA1);
        cycle(1, 0, 0, CK);
        chk("lit_b2b_stage", 32'(stage8), 32'd0);

        run_keys(CK, CK, CK, CK, 20);
        chk("lit_sat_result8", 32'(result8), 32'h18);
        chk("lit_sat_result4", 32'(result4), 32'hF);
        cycle(0, 0, 0, CK);

        cycle(1, 0, 0, CK);
        cycle(0, 1, 0, CK);
        cycle(0, 1, 0, CK);
        chk("lit_g2_stage", 32'(stage8), 32'd3);
        cycle(0, 1, 1, CK);
        chk("lit_abort_stage",  32'(stage8),  32'd0);
        chk("lit_abort_done",   32'(done8),   32'd0);
        chk("lit_abort_result", 32'(result8), 32'h18);
        cycle(0, 0, 0, CK);
        chk("lit_abort_nodone", 32'(done8), 32'd0);

        cycle(1, 0, 0, CK);
        cycle(0, 1, 0, 4'b1011);
        cycle(0, 1, 0, CK);
        chk("lit_d2_stage", 32'(stage8), 32'd3);
        rst = 1'b0;
        #1;
        chk("lit_midrst_stage",  32'(stage8),  32'd0);
        chk("lit_midrst_busy",   32'(busy8),   32'd0);
        chk("lit_midrst_done",   32'(done8),   32'd0);
        chk("lit_midrst_result", 32'(result8), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run_keys(CK, CK, CK, CK, 0);
        chk("lit_postrst_result8", 32'(result8), 32'h04);
        cycle(0, 0, 0, CK);

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 40) == 0,
                  ($urandom % 2 == 0) ? CK : 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keyed_dup_seq.md
# keyed_dup_seq

Parametrised successor to the team's single-key duplicated-state locked controllers. It is a sequencing FSM with `NKEY` key-checked checkpoints. Every genuine checkpoint state has a decoy twin whose outputs are identical. A wrong key bit at any checkpoint diverts the machine onto the decoy chain, and the machine stays there for the rest of the run. On the decoy chain the payload result is silently corrupted. The block sits in the locking benchmark set as the generalised N-key, counter-bearing reference controller.

## Interface
- `NKEY`, 4: number of checkpoints and key bits, 1..8.
- `CORRECT_KEY`, `4'b1010`: correct key, `NKEY` bits wide; bit i checks checkpoint i.
- `CW`, 8: cycle-counter and result width.
- `DECOY_MASK`, `8'hA5`: XOR mask applied to the result on the decoy path, `CW` bits wide.
- `clk` in 1: single clock; all state updates occur on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `adv` in 1: advance from the current checkpoint.
- `abort` in 1: return to IDLE from any non-IDLE state.
- `keyinput` in `NKEY`: key bits; read live, never latched.
- `stage` out `$clog2(NKEY+2)`: 0 in IDLE, i+1 in checkpoint i (either twin), `NKEY`+1 in FIN.
- `busy` out 1: high in every checkpoint state and its twin.
- `done` out 1: one-cycle pulse in FIN or DFIN.
- `result` out `CW`: run length, valid while `done` is high; holds its value otherwise.

## Operation
- States:
  - IDLE.
  - G0..G(NKEY-1), the genuine chain.
  - D1..D(NKEY-1), the decoys. There is no D0, because checkpoint 0 is always entered genuinely.
  - FIN and DFIN.
- IDLE & `start` → G0. Counter `cnt` cleared to 0.
- Gi & `adv`:
  - If `keyinput[i]` == `CORRECT_KEY[i]`: go to G(i+1), or to FIN when i = `NKEY`-1.
  - Otherwise: go to D(i+1), or to DFIN when i = `NKEY`-1.
- Di & `adv` → D(i+1), or DFIN when i = `NKEY`-1. The key is ignored once on the decoy chain; there is no path back to the genuine chain.
- A checkpoint state without `adv` holds its state; `cnt` increments by 1, saturating at all-ones.
- A checkpoint state with `adv` also increments `cnt` by 1 in the transition cycle.
- FIN: `result` ← `cnt`, `done`=1, next state IDLE.
- DFIN: `result` ← `cnt` ^ `DECOY_MASK`, `done`=1, next state IDLE.
- Twin outputs: Gi and Di drive identical `stage`, `busy` and `done`; FIN and DFIN differ only in `result`.
- Priority in a checkpoint state: `abort` > `adv`. On `abort`: next state IDLE, `result` unchanged, no `done`.
- Other abort cases:
  - `abort` in FIN or DFIN is ignored; the `done` pulse still completes.
  - `start` asserted outside IDLE is ignored.
- Unreachable or illegal state encoding → IDLE on the next edge.
- Reset:
  - State IDLE, `cnt`=0, `result`=0.
  - `stage`=0, `busy`=0, `done`=0.
  - Takes effect immediately when `rst` falls, including mid-run.

## Timing
- All outputs are Moore outputs decoded from the registered state; `result` is a register. There are no combinational input-to-output paths.
- Latency:
  - `start` at edge n → `busy`=1 from n+1.
  - Final `adv` at edge m → `done`=1 and `result` valid during cycle m+1.
  - Back in IDLE at m+2.
- Minimum run: `NKEY`+2 cycles from `start` to IDLE, with `adv` held high.
- `cnt` counts cycles spent in checkpoint states. With `adv` held continuously, `result` = `NKEY` on the genuine path.
- `keyinput` only matters in the cycle where `adv` is high in Gi.
- Back-to-back runs: `start` may be asserted in the IDLE cycle that directly follows the `done` cycle.

## Structure
- Shared package `keyed_dup_pkg` holds:
  - The state-encoding localparam scheme: IDLE=0, Gi=1+i, Di=1+`NKEY`+i, FIN, DFIN.
  - A function mapping state → `stage`.
- One sub-module, `sat_cnt`: `CW`-bit saturating counter with clear and enable. Reused by the other locked controllers in the set.
- Top level: state register, next-state logic, output decode, result register.

## Test plan
- Correct key: `NKEY`=4, key=`4'b1010`, `start`, then `adv` high for 4 cycles → `stage` 1,2,3,4,5; `done` pulse; `result`=4; IDLE.
- Wrong bit 0: key=`4'b1011`, same stimulus → `stage`/`busy`/`done` sequence identical to the correct-key run; `result`=`8'h04`^`8'hA5`=`8'hA1`.
- Decoy persistence: key wrong at checkpoint 1, then corrected before checkpoints 2 and 3 → still DFIN; `result` masked.
- Stall and saturate: `CW`=4, `adv` held low for 20 cycles in G0, then 4 `adv` → `result`=`4'hF`.
- `abort` and `adv` together in G2 → IDLE next cycle; no `done`; `result` keeps its previous value.
- `rst` low in D2 → all outputs 0 immediately; after release, a `start` with the correct key gives `result`=4.
